// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl: turns PS/2 set-2 scan-code bytes into press/release events
// for the nine game keys. It decodes the E0/F0 prefixes, drops typematic repeats,
// keeps a held-key bitmap and queues events in a small FIFO.
// Latency: a byte sampled at edge N is written to the FIFO at edge N, so it is
// visible from cycle N+1. Backpressure: the FIFO drains when evt_valid&evt_ready.
// If the FIFO is full the event is dropped and overflow sticks high.
// Ports: clk/rst (async, active-high); byte_valid/byte_data from the PS/2 receiver;
// evt_valid/evt_ready/evt_key/evt_press show the FIFO head; held is the bitmap of
// keys down; overflow is sticky; seq_err pulses on a prefix timeout or a bad prefix.
module ps2_key_event_ctrl #(
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [3:0] evt_key,
  output logic       evt_press,
  output logic [8:0] held,
  output logic       overflow,
  output logic       seq_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRE_E0, PRE_F0, PRE_E0F0} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [8:0]     held_q, held_d;
  logic           ovf_q, ovf_d;
  logic           seq_err_q, seq_err_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [3:0]     last_key_q, last_key_d;
  logic           last_press_q, last_press_d;
  logic [3:0]     mem_key_q   [FIFO_DEPTH];
  logic [3:0]     mem_key_d   [FIFO_DEPTH];
  logic           mem_press_q [FIFO_DEPTH];
  logic           mem_press_d [FIFO_DEPTH];

  logic       map_hit;
  logic [3:0] map_idx;
  logic       cand_make, cand_break;
  logic       push_req, new_press;
  logic       fifo_empty, fifo_full, pop, push;

  // Scan-code to mole index.
  always_comb begin
    map_hit = 1'b1;
    map_idx = 4'd0;
    case (byte_data)
      8'h15: map_idx = 4'd0;
      8'h1D: map_idx = 4'd1;
      8'h24: map_idx = 4'd2;
      8'h1C: map_idx = 4'd3;
      8'h1B: map_idx = 4'd4;
      8'h23: map_idx = 4'd5;
      8'h1A: map_idx = 4'd6;
      8'h22: map_idx = 4'd7;
      8'h21: map_idx = 4'd8;
      default: map_hit = 1'b0;
    endcase
  end

  // Prefix sequencer and timeout.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    seq_err_d  = 1'b0;
    cand_make  = 1'b0;
    cand_break = 1'b0;
    if (byte_valid) begin
      // A byte always wins over a coincident terminal count.
      cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (byte_data == 8'hE0)      state_d = PRE_E0;
          else if (byte_data == 8'hF0) state_d = PRE_F0;
          else                         cand_make = map_hit;
        end
        PRE_E0: begin
          if (byte_data == 8'hF0)      state_d = PRE_E0F0;
          else if (byte_data != 8'hE0) state_d = IDLE;
        end
        PRE_F0: begin
          state_d    = IDLE;
          cand_break = map_hit;
          seq_err_d  = (byte_data == 8'hE0) || (byte_data == 8'hF0);
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (cnt_q == CNT_LAST) begin
        state_d   = IDLE;
        seq_err_d = 1'b1;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Held bitmap and event generation; held changes even if the push is dropped.
  always_comb begin
    held_d    = held_q;
    push_req  = 1'b0;
    new_press = 1'b0;
    if (cand_make && !held_q[map_idx]) begin
      held_d[map_idx] = 1'b1;
      push_req        = 1'b1;
      new_press       = 1'b1;
    end
    if (cand_break && held_q[map_idx]) begin
      held_d[map_idx] = 1'b0;
      push_req        = 1'b1;
    end
  end

  // Event FIFO: extra pointer MSB separates full from empty.
  always_comb begin
    fifo_empty   = (wr_ptr_q == rd_ptr_q);
    fifo_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop          = !fifo_empty && evt_ready;
    push         = push_req && (!fifo_full || pop);
    ovf_d        = ovf_q || (push_req && fifo_full && !pop);
    wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    mem_key_d    = mem_key_q;
    mem_press_d  = mem_press_q;
    last_key_d   = last_key_q;
    last_press_d = last_press_q;
    if (push) begin
      mem_key_d[wr_ptr_q[AW-1:0]]   = map_idx;
      mem_press_d[wr_ptr_q[AW-1:0]] = new_press;
    end
    // Remember the popped entry so the outputs hold it once the FIFO empties.
    if (pop) begin
      last_key_d   = mem_key_q[rd_ptr_q[AW-1:0]];
      last_press_d = mem_press_q[rd_ptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      held_q       <= '0;
      ovf_q        <= 1'b0;
      seq_err_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      last_key_q   <= '0;
      last_press_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_key_q[i]   <= '0;
        mem_press_q[i] <= 1'b0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      held_q       <= held_d;
      ovf_q        <= ovf_d;
      seq_err_q    <= seq_err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      last_key_q   <= last_key_d;
      last_press_q <= last_press_d;
      mem_key_q    <= mem_key_d;
      mem_press_q  <= mem_press_d;
    end
  end

  assign evt_valid = !fifo_empty;
  assign evt_key   = fifo_empty ? last_key_q   : mem_key_q[rd_ptr_q[AW-1:0]];
  assign evt_press = fifo_empty ? last_press_q : mem_press_q[rd_ptr_q[AW-1:0]];
  assign held      = held_q;
  assign overflow  = ovf_q;
  assign seq_err   = seq_err_q;

endmodule

// File: doc/ps2_key_event_ctrl.md
Name: ps2_key_event_ctrl

Overview:
Sequences the raw scan-code byte stream from the PS/2 receiver into clean press/release events for the nine whack-a-mole keys. It tracks the E0/F0 prefixes, suppresses typematic repeats, keeps a held-key bitmap and buffers events in a small FIFO. Game logic drains the FIFO through a valid/ready handshake. It sits between the PS/2 receiver's per-byte strobe and the game FSM.

Parameters:
TIMEOUT_CYCLES, 2000000, clk cycles a prefix may wait for its next byte (20 ms at 100 MHz) before the sequence is abandoned
FIFO_DEPTH, 4, event FIFO entries; must be a power of 2 and at least 2

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
byte_valid  in  1  one-cycle strobe; byte_data holds a newly received scan-code byte
byte_data  in  8  scan-code byte, set 2
evt_ready  in  1  game logic accepts the head event
evt_valid  out  1  FIFO non-empty; the head event is presented
evt_key  out  4  mole index 0..8 of the head event
evt_press  out  1  1 = make, 0 = break, for the head event
held  out  9  bitmap of keys currently held
overflow  out  1  sticky; an event was dropped because the FIFO was full
seq_err  out  1  one-cycle pulse on a prefix timeout or a malformed prefix

Behaviour:
- Async reset, any cycle, including mid-sequence:
  - FSM returns to IDLE; FIFO is emptied.
  - evt_valid=0, evt_key=0, evt_press=0, held=0, overflow=0, seq_err=0; timeout counter=0.
- Key map, scan code to index:
  - 15→0 (Q), 1D→1 (W), 24→2 (E), 1C→3 (A), 1B→4 (S).
  - 23→5 (D), 1A→6 (Z), 22→7 (X), 21→8 (C).
  - Any other code is unmapped.
- FSM states: IDLE, PRE_E0, PRE_F0, PRE_E0F0. Transitions are evaluated only when byte_valid=1:
  - IDLE:
    - E0 → PRE_E0.
    - F0 → PRE_F0.
    - Mapped code → make candidate, stay in IDLE.
    - Anything else → ignored.
  - PRE_E0:
    - F0 → PRE_E0F0.
    - E0 → stay in PRE_E0.
    - Any other byte → IDLE, no event. Extended keys are never mapped.
  - PRE_F0:
    - Mapped code → break candidate, then IDLE.
    - E0 or F0 → seq_err pulse, then IDLE.
    - Other byte → IDLE.
  - PRE_E0F0: any byte → IDLE, no event.
- Event generation:
  - Make candidate with held[k]=0: set held[k], push {k,1}.
  - Make candidate with held[k]=1: typematic repeat; no push.
  - Break candidate with held[k]=1: clear held[k], push {k,0}.
  - Break candidate with held[k]=0: no push, held unchanged.
- held updates even when the push is dropped.
- Latency: byte_valid sampled at edge N → FIFO write at edge N. If the FIFO was empty, evt_valid=1 from cycle N+1.
- FIFO:
  - Pop on the edge where evt_valid&evt_ready.
  - Outputs show the head entry combinationally from registered storage.
  - evt_key and evt_press hold their last value while empty.
- FIFO full:
  - Push with no pop → event dropped, overflow←1 until reset.
  - Push and pop in the same cycle while full → both happen, no overflow.
  - Push and pop while empty → the push lands; evt_valid=1 in the next cycle.
- Pointers: log2(FIFO_DEPTH)+1 bits, wrap naturally; full and empty are decided by the extra MSB.
- Timeout:
  - In any non-IDLE state, the counter increments each cycle without byte_valid.
  - The counter clears on byte_valid or on entry to IDLE.
  - When it reaches TIMEOUT_CYCLES-1 with no byte_valid: go to IDLE, seq_err pulses 1 cycle, counter clears.
  - If byte_valid coincides with the terminal count, the byte wins: it is processed normally and there is no seq_err.
- seq_err is registered and high for exactly one cycle per fault.

Test Plan:
- Reset, then bytes 1C, F0, 1C with gaps of 10 cycles, evt_ready=1 → two events {3,press} then {3,release}; held[3] goes 1 then 0; each evt_valid lasts 1 cycle.
- Bytes 15,15,15 then F0,15 → exactly one press{0} and one release{0}; held=000000001 between them.
- evt_ready=0, send makes for keys 0..4 (5 events, FIFO_DEPTH=4) → first 4 buffered in order 0,1,2,3; overflow=1; held=000011111; raise evt_ready → 4 pops, then evt_valid=0.
- E0, 1C then E0, F0, 1C, then F0, 22 with held[7]=0 → no events; FSM back in IDLE; seq_err stays 0.
- F0 then no byte for TIMEOUT_CYCLES (set to 16 for the bench) → seq_err pulse at cycle 16; a following 1D yields press{1}, not release.
- Assert rst mid-sequence after E0, F0 with 2 events queued → evt_valid=0, held=0, overflow=0 immediately; after release, 24 yields press{2}.
